// File: rtl/dff_ctrl_pkg.sv
// Shared definitions for the two-phase write arbiter: FSM state encoding
// and the width helper used for requester indices.
package dff_ctrl_pkg;

    // 2'd3 is not a legal state; the FSM steers it back to IDLE.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    // Bits needed to hold a requester index (owner, ptr, winner).
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: rotate the request vector so the
// search starts just above ptr, take the lowest set bit, rotate back.
module rr_pick
    import dff_ctrl_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]            req,
    input  logic [idx_width(N_REQ)-1:0] ptr,
    output logic                        any,
    output logic [idx_width(N_REQ)-1:0] idx,
    output logic [N_REQ-1:0]            sel
);
    localparam int IW = idx_width(N_REQ);

    int               start;
    int               off;
    logic [N_REQ-1:0] rot;

    // Search origin is the requester after the last winner.
    assign start = (int'(ptr) + 1) % N_REQ;
    assign any   = |req;

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rot
            assign rot[gi] = req[(start + gi) % N_REQ];
            assign sel[gi] = any && (idx == IW'(gi));
        end
    endgenerate

    // Priority-encode the rotated vector and map the offset back to an index.
    always_comb begin
        off = 0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (rot[k]) off = k;
        end
        idx = IW'((start + off) % N_REQ);
    end

endmodule

// File: rtl/dff_write_arbiter.sv
// Round-robin arbiter for a shared register: the winner's data is staged
// in LOAD, then made visible on q in COMMIT, with owner tracking.
module dff_write_arbiter
    import dff_ctrl_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*WIDTH-1:0]    wdata,
    output logic [N_REQ-1:0]          grant,
    output logic [WIDTH-1:0]          q,
    output logic [$clog2(N_REQ)-1:0]  owner,
    output logic                      valid,
    output logic                      busy
);
    localparam int IW = idx_width(N_REQ);

    state_t           state_reg, state_next;
    logic [N_REQ-1:0] grant_reg, grant_next;
    logic [WIDTH-1:0] stage_reg, stage_next;
    logic [WIDTH-1:0] q_reg, q_next;
    logic [IW-1:0]    owner_reg, owner_next;
    logic [IW-1:0]    ptr_reg, ptr_next;
    logic [IW-1:0]    win_reg, win_next;
    logic             valid_reg, valid_next;

    logic             pick_any;
    logic [IW-1:0]    pick_idx;
    logic [N_REQ-1:0] pick_sel;
    logic [WIDTH-1:0] lane [N_REQ];

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_lane
            assign lane[gi] = wdata[gi*WIDTH +: WIDTH];
        end
    endgenerate

    rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req (req),
        .ptr (ptr_reg),
        .any (pick_any),
        .idx (pick_idx),
        .sel (pick_sel)
    );

    // State and datapath registers; reset drops any write in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            grant_reg <= '0;
            stage_reg <= '0;
            q_reg     <= '0;
            owner_reg <= '0;
            ptr_reg   <= IW'(N_REQ - 1);
            win_reg   <= '0;
            valid_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            grant_reg <= grant_next;
            stage_reg <= stage_next;
            q_reg     <= q_next;
            owner_reg <= owner_next;
            ptr_reg   <= ptr_next;
            win_reg   <= win_next;
            valid_reg <= valid_next;
        end
    end

    // Next-state logic: arbitrate from IDLE/COMMIT, commit the staged word from LOAD.
    always_comb begin
        state_next = state_reg;
        grant_next = '0;
        stage_next = stage_reg;
        q_next     = q_reg;
        owner_next = owner_reg;
        ptr_next   = ptr_reg;
        win_next   = win_reg;
        valid_next = 1'b0;
        case (state_reg)
            IDLE, COMMIT: begin
                if (pick_any) begin
                    state_next = LOAD;
                    grant_next = pick_sel;
                    stage_next = lane[pick_idx];
                    win_next   = pick_idx;
                end else begin
                    state_next = IDLE;
                end
            end
            LOAD: begin
                state_next = COMMIT;
                q_next     = stage_reg;
                owner_next = win_reg;
                ptr_next   = win_reg;
                valid_next = 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end

    assign grant = grant_reg;
    assign q     = q_reg;
    assign owner = owner_reg;
    assign valid = valid_reg;
    assign busy  = (state_reg != IDLE);

endmodule

// File: tb/tb_dff_write_arbiter.sv
// Self-checking bench: a hand-derived vector table covering reset,
// saturation, wrap fairness, withdrawal and reset mid-LOAD, followed by
// randomized traffic checked against a transaction-level reference model.
module tb_dff_write_arbiter;
    localparam int N = 4;
    localparam int W = 8;

    logic             clk;
    logic             rst_n;
    logic [N-1:0]     req;
    logic [N*W-1:0]   wdata;
    logic [N-1:0]     grant;
    logic [W-1:0]     q;
    logic [1:0]       owner;
    logic             valid;
    logic             busy;

    dff_write_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .wdata (wdata),
        .grant (grant),
        .q     (q),
        .owner (owner),
        .valid (valid),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic           rst_n;
        logic [N-1:0]   req;
        logic [N*W-1:0] wdata;
        logic [N-1:0]   grant;
        logic [W-1:0]   q;
        logic [1:0]     owner;
        logic           valid;
        logic           busy;
    } vec_t;

    int vectors;
    int miscompares;

    // Reference model: one pending winner between arbitration and commit.
    logic [N-1:0] m_grant;
    logic [W-1:0] m_q;
    logic [W-1:0] m_stage;
    int           m_owner;
    int           m_last;
    int           m_pend;
    logic         m_valid;
    logic         m_busy;

    task automatic model_edge(input logic r, input logic [N-1:0] rq, input logic [N*W-1:0] wd);
        int  c;
        bit  found;
        if (!r) begin
            m_q = '0; m_owner = 0; m_valid = 1'b0; m_grant = '0;
            m_last = N - 1; m_pend = -1; m_stage = '0;
        end else if (m_pend >= 0) begin
            m_q = m_stage; m_owner = m_pend; m_last = m_pend;
            m_valid = 1'b1; m_grant = '0; m_pend = -1;
        end else begin
            m_valid = 1'b0;
            m_grant = '0;
            found = 1'b0;
            for (int k = 1; k <= N; k++) begin
                c = (m_last + k) % N;
                if (!found && rq[c]) begin
                    found = 1'b1;
                    m_pend = c;
                end
            end
            if (found) begin
                m_grant[m_pend] = 1'b1;
                m_stage = wd[m_pend*W +: W];
            end
        end
        m_busy = (m_pend >= 0) || m_valid;
    endtask

    task automatic step(input logic r, input logic [N-1:0] rq, input logic [N*W-1:0] wd);
        rst_n = r;
        req   = rq;
        wdata = wd;
        @(posedge clk);
        model_edge(r, rq, wd);
        #1;
    endtask

    task automatic check(input string tag, input logic [N-1:0] eg, input logic [W-1:0] eq,
                         input logic [1:0] eo, input logic ev, input logic eb);
        vectors++;
        if (grant !== eg) begin
            miscompares++;
            $display("FAIL %s grant: got %b want %b", tag, grant, eg);
        end
        if (q !== eq) begin
            miscompares++;
            $display("FAIL %s q: got %h want %h", tag, q, eq);
        end
        if (owner !== eo) begin
            miscompares++;
            $display("FAIL %s owner: got %0d want %0d", tag, owner, eo);
        end
        if (valid !== ev) begin
            miscompares++;
            $display("FAIL %s valid: got %b want %b", tag, valid, ev);
        end
        if (busy !== eb) begin
            miscompares++;
            $display("FAIL %s busy: got %b want %b", tag, busy, eb);
        end
        $display("%s: req=%b grant=%b q=%h owner=%0d valid=%b busy=%b",
                 tag, req, grant, q, owner, valid, busy);
    endtask

    localparam logic [N*W-1:0] LANES  = 32'h4433_2211;
    localparam logic [N*W-1:0] LANES2 = 32'h44A5_2211;

    vec_t tbl [25];

    function automatic vec_t mk(input logic r, input logic [N-1:0] rq, input logic [N*W-1:0] wd,
                                input logic [N-1:0] g, input logic [W-1:0] eq, input logic [1:0] o,
                                input logic v, input logic b);
        vec_t t;
        t.rst_n = r; t.req = rq; t.wdata = wd; t.grant = g;
        t.q = eq; t.owner = o; t.valid = v; t.busy = b;
        return t;
    endfunction

    logic [N-1:0]   rr;
    logic [N*W-1:0] rw;
    logic           rrst;

    initial begin
        vectors = 0;
        miscompares = 0;
        rst_n = 1'b0;
        req   = '0;
        wdata = '0;

        // reset held with all requests asserted, then released
        tbl[0]  = mk(0, 4'hF,    LANES,  4'b0000, 8'h00, 0, 0, 0);
        tbl[1]  = mk(0, 4'hF,    LANES,  4'b0000, 8'h00, 0, 0, 0);
        tbl[2]  = mk(1, 4'h0,    LANES,  4'b0000, 8'h00, 0, 0, 0);
        // saturation: grants 0,1,2,3 two cycles apart
        tbl[3]  = mk(1, 4'hF,    LANES,  4'b0001, 8'h00, 0, 0, 1);
        tbl[4]  = mk(1, 4'hF,    LANES,  4'b0000, 8'h11, 0, 1, 1);
        tbl[5]  = mk(1, 4'hF,    LANES,  4'b0010, 8'h11, 0, 0, 1);
        tbl[6]  = mk(1, 4'hF,    LANES,  4'b0000, 8'h22, 1, 1, 1);
        tbl[7]  = mk(1, 4'hF,    LANES,  4'b0100, 8'h22, 1, 0, 1);
        tbl[8]  = mk(1, 4'hF,    LANES,  4'b0000, 8'h33, 2, 1, 1);
        tbl[9]  = mk(1, 4'hF,    LANES,  4'b1000, 8'h33, 2, 0, 1);
        tbl[10] = mk(1, 4'hF,    LANES,  4'b0000, 8'h44, 3, 1, 1);
        // wrap fairness: after 3 commits, 4'b1001 grants 0 then 3
        tbl[11] = mk(1, 4'b1001, LANES,  4'b0001, 8'h44, 3, 0, 1);
        tbl[12] = mk(1, 4'b1001, LANES,  4'b0000, 8'h11, 0, 1, 1);
        tbl[13] = mk(1, 4'b1001, LANES,  4'b1000, 8'h11, 0, 0, 1);
        tbl[14] = mk(1, 4'b0000, LANES,  4'b0000, 8'h44, 3, 1, 1);
        tbl[15] = mk(1, 4'b0000, LANES,  4'b0000, 8'h44, 3, 0, 0);
        // single request on lane 2, req[1] pulses during LOAD and is withdrawn
        tbl[16] = mk(1, 4'b0100, LANES2, 4'b0100, 8'h44, 3, 0, 1);
        tbl[17] = mk(1, 4'b0010, LANES2, 4'b0000, 8'hA5, 2, 1, 1);
        tbl[18] = mk(1, 4'b0000, LANES2, 4'b0000, 8'hA5, 2, 0, 0);
        tbl[19] = mk(1, 4'b0000, LANES2, 4'b0000, 8'hA5, 2, 0, 0);
        // reset while requester 1 is in LOAD, then requester 0 wins first
        tbl[20] = mk(1, 4'b0010, LANES,  4'b0010, 8'hA5, 2, 0, 1);
        tbl[21] = mk(0, 4'b0010, LANES,  4'b0000, 8'h00, 0, 0, 0);
        tbl[22] = mk(1, 4'hF,    LANES,  4'b0001, 8'h00, 0, 0, 1);
        tbl[23] = mk(1, 4'h0,    LANES,  4'b0000, 8'h11, 0, 1, 1);
        tbl[24] = mk(1, 4'h0,    LANES,  4'b0000, 8'h11, 0, 0, 0);

        for (int i = 0; i < 25; i++) begin
            step(tbl[i].rst_n, tbl[i].req, tbl[i].wdata);
            check($sformatf("vec%0d", i), tbl[i].grant, tbl[i].q, tbl[i].owner,
                  tbl[i].valid, tbl[i].busy);
        end

        // Randomized traffic: requesters keep req and lane stable until granted,
        // may withdraw early, and reset is asserted occasionally.
        rr = '0;
        rw = LANES;
        for (int t = 0; t < 400; t++) begin
            for (int i = 0; i < N; i++) begin
                if (m_grant[i]) begin
                    rr[i] = ($urandom_range(0, 1) == 0);
                    rw[i*W +: W] = W'($urandom);
                end else if (!rr[i]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        rr[i] = 1'b1;
                        rw[i*W +: W] = W'($urandom);
                    end
                end else if ($urandom_range(0, 15) == 0) begin
                    rr[i] = 1'b0;
                end
            end
            rrst = ($urandom_range(0, 49) != 0);
            if (!rrst) rr = '0;
            step(rrst, rr, rw);
            check($sformatf("rnd%0d", t), m_grant, m_q, 2'(m_owner), m_valid, m_busy);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
